// File: rtl/drive_arbiter4.sv
// drive_arbiter4: grants one of four requesters, emits a registered drive pulse to a mutex merge, acks on the synchronized free return.
// Fixed priority (ch0 highest) by default; define DRIVE_ARB_ROUND_ROBIN_EN for round-robin arbitration.
module drive_arbiter4 #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i_req,
  output logic [3:0] o_ack,
  output logic       o_drive0,
  output logic       o_drive1,
  output logic       o_drive2,
  output logic       o_drive3,
  input  logic       i_free0,
  input  logic       i_free1,
  input  logic       i_free2,
  input  logic       i_free3,
  output logic [1:0] o_grant,
  output logic       o_busy
);

  localparam int         GAP_LEN    = (GAP_W < 1) ? 1 : GAP_W;
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_LEN - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, WAIT_FREE, GAP} state_e;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] grant_q, grant_d;
  logic [3:0] drive_q, drive_d;
  logic [3:0] ack_q, ack_d;
  logic       pend_q, pend_d;
  logic [3:0] free_s1_q, free_s2_q, free_h_q;
  logic [3:0] free_evt;
  logic       mine_free;
  logic [1:0] pick;

  // Free returns are asynchronous: two-flop synchronizer, then a history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      free_s1_q <= '0;
      free_s2_q <= '0;
      free_h_q  <= '0;
    end else begin
      free_s1_q <= {i_free3, i_free2, i_free1, i_free0};
      free_s2_q <= free_s1_q;
      free_h_q  <= free_s2_q;
    end
  end

  assign free_evt  = free_s2_q & ~free_h_q;
  assign mine_free = free_evt[grant_q];

`ifdef DRIVE_ARB_ROUND_ROBIN_EN
  logic [1:0] ptr_q;

  always_comb begin
    pick = ptr_q;
    for (int i = 3; i >= 0; i--) begin
      if (i_req[ptr_q + 2'(i)]) pick = ptr_q + 2'(i);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q <= '0;
    end else if (state_q == IDLE && |i_req) begin
      ptr_q <= pick + 2'd1;
    end
  end
`else
  always_comb begin
    pick = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (i_req[i]) pick = 2'(i);
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    grant_d = grant_q;
    pend_d  = pend_q;
    ack_d   = '0;
    case (state_q)
      IDLE: begin
        if (|i_req) begin
          state_d = DRIVE;
          grant_d = pick;
          cnt_d   = '0;
          pend_d  = 1'b0;
        end
      end
      DRIVE: begin
        // An early free must survive until WAIT_FREE, since the edge detector fires only once.
        if (mine_free) pend_d = 1'b1;
        if (cnt_q == PULSE_LAST) begin
          state_d = WAIT_FREE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      WAIT_FREE: begin
        if (mine_free || pend_q) begin
          state_d         = GAP;
          pend_d          = 1'b0;
          ack_d[grant_q]  = 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) state_d = IDLE;
        else                   cnt_d   = cnt_q + 4'd1;
      end
      default: state_d = IDLE;
    endcase
    drive_d = '0;
    if (state_d == DRIVE) drive_d[grant_d] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      grant_q <= '0;
      pend_q  <= 1'b0;
      drive_q <= '0;
      ack_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      grant_q <= grant_d;
      pend_q  <= pend_d;
      drive_q <= drive_d;
      ack_q   <= ack_d;
    end
  end

  assign o_drive0 = drive_q[0];
  assign o_drive1 = drive_q[1];
  assign o_drive2 = drive_q[2];
  assign o_drive3 = drive_q[3];
  assign o_ack    = ack_q;
  assign o_grant  = grant_q;
  assign o_busy   = (state_q != IDLE);

endmodule
